// File: rtl/lcd_text_ctrl.sv
// rtl/lcd_text_ctrl.sv - HD44780-class character LCD controller with a ROWS x COLS text buffer
// Runs the power-on init once, then redraws the whole panel whenever the buffer is dirty.
module lcd_text_ctrl #(
  parameter int ROWS      = 2,
  parameter int COLS      = 16,
  parameter int EN_CYCLES = 16,
  parameter int CMD_DLY   = 262142,
  parameter int CLR_DLY   = 1048568,
  parameter bit BLON_VAL  = 1'b0,
  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_en,
  input  logic [RW-1:0] wr_row,
  input  logic [CW-1:0] wr_col,
  input  logic [7:0]    wr_char,
  input  logic          refresh_req,
  output logic          busy,
  output logic [7:0]    LCD_DATA,
  output logic          LCD_RS,
  output logic          LCD_EN,
  output logic          LCD_RW,
  output logic          LCD_ON,
  output logic          LCD_BLON
);

  localparam int PW      = $clog2(COLS + 1);
  localparam int MAX_DLY = (CMD_DLY > CLR_DLY) ? CMD_DLY : CLR_DLY;
  localparam int MAX_CNT = (MAX_DLY > EN_CYCLES) ? MAX_DLY : EN_CYCLES;
  localparam int TW      = $clog2(MAX_CNT + 1);

  typedef enum logic [1:0] {ST_INIT, ST_DRAW, ST_IDLE} state_t;
  typedef enum logic [1:0] {PH_START, PH_SETUP, PH_PULSE, PH_WAIT} phase_t;

  state_t        r_state, w_state_n;
  phase_t        r_phase;
  logic [1:0]    r_init_idx, w_init_idx_n;
  logic [RW-1:0] r_row, w_row_n;
  logic [PW-1:0] r_pos, w_pos_n;
  logic [TW-1:0] r_cnt;
  logic          r_dirty;
  logic          r_clr;
  logic [7:0]    r_buf [ROWS][COLS];

  logic          w_load, w_frame_start, w_wait_done;
  logic          w_wr_ok, w_set_dirty;
  logic [7:0]    w_byte;
  logic          w_rs, w_is_clr;
  logic [CW-1:0] w_rd_col;
  logic [1:0]    w_row2;

  assign w_wait_done = (r_phase == PH_WAIT) && (r_cnt == '0);
  assign w_wr_ok     = wr_en && (int'(wr_row) < ROWS) && (int'(wr_col) < COLS);
  assign w_set_dirty = w_wr_ok || refresh_req;

  // r_pos 0 is the row address command, 1..COLS are the character cells.
  always_comb begin
    w_state_n     = r_state;
    w_init_idx_n  = r_init_idx;
    w_row_n       = r_row;
    w_pos_n       = r_pos;
    w_load        = 1'b0;
    w_frame_start = 1'b0;
    case (r_state)
      ST_INIT: begin
        if (r_phase == PH_START) begin
          w_load = 1'b1;
        end else if (w_wait_done) begin
          w_load = 1'b1;
          if (r_init_idx == 2'd3) begin
            w_state_n     = ST_DRAW;
            w_row_n       = '0;
            w_pos_n       = '0;
            w_frame_start = 1'b1;
          end else begin
            w_init_idx_n = r_init_idx + 2'd1;
          end
        end
      end
      ST_DRAW: begin
        if (w_wait_done) begin
          if (r_pos != PW'(COLS)) begin
            w_pos_n = r_pos + PW'(1);
            w_load  = 1'b1;
          end else if (r_row != RW'(ROWS - 1)) begin
            w_row_n = r_row + RW'(1);
            w_pos_n = '0;
            w_load  = 1'b1;
          end else if (r_dirty) begin
            w_row_n       = '0;
            w_pos_n       = '0;
            w_load        = 1'b1;
            w_frame_start = 1'b1;
          end else begin
            w_state_n = ST_IDLE;
          end
        end
      end
      ST_IDLE: begin
        if (r_dirty) begin
          w_state_n     = ST_DRAW;
          w_row_n       = '0;
          w_pos_n       = '0;
          w_load        = 1'b1;
          w_frame_start = 1'b1;
        end
      end
      default: w_state_n = ST_INIT;
    endcase
  end

  // Byte selected from the next sequence position; buffer read happens on the SETUP edge.
  always_comb begin
    w_byte   = 8'h00;
    w_rs     = 1'b0;
    w_is_clr = 1'b0;
    w_rd_col = CW'(w_pos_n - PW'(1));
    w_row2   = 2'(w_row_n);
    if (w_state_n == ST_INIT) begin
      case (w_init_idx_n)
        2'd0:    w_byte = 8'h38;
        2'd1:    w_byte = 8'h0C;
        2'd2: begin
          w_byte   = 8'h01;
          w_is_clr = 1'b1;
        end
        default: w_byte = 8'h06;
      endcase
    end else if (w_pos_n == '0) begin
      case (w_row2)
        2'd0:    w_byte = 8'h80;
        2'd1:    w_byte = 8'hC0;
        2'd2:    w_byte = 8'h80 | 8'(COLS);
        default: w_byte = 8'h80 | (8'h40 + 8'(COLS));
      endcase
    end else begin
      w_byte = r_buf[w_row_n][w_rd_col];
      w_rs   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_INIT;
      r_init_idx <= '0;
      r_row      <= '0;
      r_pos      <= '0;
    end else begin
      r_state    <= w_state_n;
      r_init_idx <= w_init_idx_n;
      r_row      <= w_row_n;
      r_pos      <= w_pos_n;
    end
  end

  // Byte engine: SETUP (1) -> PULSE (EN_CYCLES) -> WAIT (CMD_DLY or CLR_DLY).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_phase  <= PH_START;
      r_cnt    <= '0;
      r_clr    <= 1'b0;
      LCD_EN   <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else if (w_load) begin
      LCD_DATA <= w_byte;
      LCD_RS   <= w_rs;
      r_clr    <= w_is_clr;
      LCD_EN   <= 1'b0;
      r_phase  <= PH_SETUP;
      r_cnt    <= '0;
    end else begin
      case (r_phase)
        PH_SETUP: begin
          LCD_EN  <= 1'b1;
          r_phase <= PH_PULSE;
          r_cnt   <= TW'(EN_CYCLES - 1);
        end
        PH_PULSE: begin
          if (r_cnt == '0) begin
            LCD_EN  <= 1'b0;
            r_phase <= PH_WAIT;
            r_cnt   <= r_clr ? TW'(CLR_DLY - 1) : TW'(CMD_DLY - 1);
          end else begin
            r_cnt <= r_cnt - TW'(1);
          end
        end
        PH_WAIT: begin
          if (r_cnt == '0) r_phase <= PH_START;
          else             r_cnt   <= r_cnt - TW'(1);
        end
        default: r_phase <= PH_START;
      endcase
    end
  end

  // A write or refresh in the frame-start cycle wins, guaranteeing one more frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dirty <= 1'b0;
      for (int r = 0; r < ROWS; r++)
        for (int c = 0; c < COLS; c++)
          r_buf[r][c] <= 8'h20;
    end else begin
      if (w_wr_ok) r_buf[wr_row][wr_col] <= wr_char;
      if (w_set_dirty)        r_dirty <= 1'b1;
      else if (w_frame_start) r_dirty <= 1'b0;
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = BLON_VAL;

endmodule

// File: tb/tb_lcd_text_ctrl.sv
// tb/tb_lcd_text_ctrl.sv - directed bench for lcd_text_ctrl
// Instance a uses the 2x4 plan geometry; instance b (3x5) reaches out-of-range addresses.
module tb_lcd_text_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       wr_en = 1'b0, refresh_req = 1'b0;
  logic [0:0] wr_row = '0;
  logic [1:0] wr_col = '0;
  logic [7:0] wr_char = '0;
  logic       busy, lcd_rs, lcd_en, lcd_rw, lcd_on, lcd_blon;
  logic [7:0] lcd_data;

  logic       wr_en_b = 1'b0, refresh_req_b = 1'b0;
  logic [1:0] wr_row_b = '0;
  logic [2:0] wr_col_b = '0;
  logic [7:0] wr_char_b = '0;
  logic       busy_b, lcd_rs_b, lcd_en_b, lcd_rw_b, lcd_on_b, lcd_blon_b;
  logic [7:0] lcd_data_b;

  lcd_text_ctrl #(.ROWS(2), .COLS(4), .EN_CYCLES(2), .CMD_DLY(10), .CLR_DLY(40), .BLON_VAL(1'b0)) u_dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_row(wr_row), .wr_col(wr_col), .wr_char(wr_char),
    .refresh_req(refresh_req), .busy(busy), .LCD_DATA(lcd_data), .LCD_RS(lcd_rs), .LCD_EN(lcd_en),
    .LCD_RW(lcd_rw), .LCD_ON(lcd_on), .LCD_BLON(lcd_blon));

  lcd_text_ctrl #(.ROWS(3), .COLS(5), .EN_CYCLES(2), .CMD_DLY(10), .CLR_DLY(40), .BLON_VAL(1'b0)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en_b), .wr_row(wr_row_b), .wr_col(wr_col_b), .wr_char(wr_char_b),
    .refresh_req(refresh_req_b), .busy(busy_b), .LCD_DATA(lcd_data_b), .LCD_RS(lcd_rs_b), .LCD_EN(lcd_en_b),
    .LCD_RW(lcd_rw_b), .LCD_ON(lcd_on_b), .LCD_BLON(lcd_blon_b));

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [8:0] q_a[$], q_b[$], exp_q[$];
  int         rise_a[$], wid_a[$], unstable_a[$];
  logic       en_prev_a = 1'b0, en_prev_b = 1'b0;
  logic [8:0] bus_prev_a = '0;

  always @(negedge clk) begin
    if (lcd_en && !en_prev_a) begin
      q_a.push_back({lcd_rs, lcd_data});
      rise_a.push_back(cyc);
    end
    if (!lcd_en && en_prev_a && rise_a.size() > 0) wid_a.push_back(cyc - rise_a[rise_a.size()-1]);
    if (en_prev_a && ({lcd_rs, lcd_data} != bus_prev_a)) unstable_a.push_back(cyc);
    en_prev_a  <= lcd_en;
    bus_prev_a <= {lcd_rs, lcd_data};
  end

  always @(negedge clk) begin
    if (lcd_en_b && !en_prev_b) q_b.push_back({lcd_rs_b, lcd_data_b});
    en_prev_b <= lcd_en_b;
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_idle(input string tag, input bit use_b);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (((use_b ? busy_b : busy) !== 1'b0) && n < 4000);
    chk({tag, " idle"}, {31'd0, (use_b ? busy_b : busy)}, 32'd0);
  endtask

  task automatic cmp_bytes(input string tag, input bit use_b);
    logic [8:0] got[$];
    if (use_b) got = q_b;
    else       got = q_a;
    chk({tag, " count"}, got.size(), exp_q.size());
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      chk($sformatf("%s byte%0d", tag, i), {23'd0, got[i]}, {23'd0, exp_q[i]});
    exp_q.delete();
    if (use_b) q_b.delete();
    else       q_a.delete();
  endtask

  task automatic exp_row(input logic [7:0] addr, input logic [39:0] cells, input int n);
    exp_q.push_back({1'b0, addr});
    for (int i = 0; i < n; i++) exp_q.push_back({1'b1, cells[8*(n-1-i) +: 8]});
  endtask

  task automatic exp_init();
    exp_q.push_back(9'h038);
    exp_q.push_back(9'h00C);
    exp_q.push_back(9'h001);
    exp_q.push_back(9'h006);
  endtask

  task automatic check_powerup(input string tag, input int t0);
    int wmin = 999, wmax = 0;
    wait_idle(tag, 1'b0);
    chk({tag, " busy fall"}, cyc - t0 - 1, 212);
    chk({tag, " pulses"}, rise_a.size(), 14);
    if (rise_a.size() >= 5) begin
      chk({tag, " first rise"}, rise_a[0] - t0, 2);
      chk({tag, " period 38"}, rise_a[1] - rise_a[0], 13);
      chk({tag, " period 01"}, rise_a[3] - rise_a[2], 43);
      chk({tag, " period 06"}, rise_a[4] - rise_a[3], 13);
    end
    foreach (wid_a[i]) begin
      if (wid_a[i] < wmin) wmin = wid_a[i];
      if (wid_a[i] > wmax) wmax = wid_a[i];
    end
    chk({tag, " en min"}, wmin, 2);
    chk({tag, " en max"}, wmax, 2);
    chk({tag, " bus stable"}, unstable_a.size(), 0);
    exp_init();
    exp_row(8'h80, 40'h20202020, 4);
    exp_row(8'hC0, 40'h20202020, 4);
    cmp_bytes(tag, 1'b0);
    rise_a.delete();
    wid_a.delete();
    unstable_a.delete();
  endtask

  task automatic write_a(input string tag, input logic [0:0] r, input logic [1:0] c, input logic [7:0] ch);
    @(negedge clk);
    wr_row = r; wr_col = c; wr_char = ch; wr_en = 1'b1;
    @(negedge clk);
    wr_en = 1'b0;
    @(negedge clk);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic refresh_a(input string tag);
    @(negedge clk);
    refresh_req = 1'b1;
    @(negedge clk);
    refresh_req = 1'b0;
    @(negedge clk);
    chk({tag, " busy"}, {31'd0, busy}, 32'd1);
  endtask

  task automatic write_b(input logic [1:0] r, input logic [2:0] c, input logic [7:0] ch);
    @(negedge clk);
    wr_row_b = r; wr_col_b = c; wr_char_b = ch; wr_en_b = 1'b1;
    @(negedge clk);
    wr_en_b = 1'b0;
  endtask

  initial begin
    int t0, n, hi;

    repeat (3) @(negedge clk);
    chk("rst en", {31'd0, lcd_en}, 0);
    chk("rst rs", {31'd0, lcd_rs}, 0);
    chk("rst data", {24'd0, lcd_data}, 0);
    chk("rst busy", {31'd0, busy}, 1);
    chk("rst busy b", {31'd0, busy_b}, 1);
    chk("rw", {31'd0, lcd_rw}, 0);
    chk("on", {31'd0, lcd_on}, 1);
    chk("blon", {31'd0, lcd_blon}, 0);

    rst_n = 1'b1;
    t0 = cyc;
    check_powerup("powerup", t0);

    write_a("idle write", 1'b1, 2'd2, 8'h41);
    wait_idle("idle write", 1'b0);
    exp_row(8'h80, 40'h20202020, 4);
    exp_row(8'hC0, 40'h20204120, 4);
    cmp_bytes("idle write", 1'b0);

    refresh_a("midframe refresh");
    n = 0;
    while (q_a.size() < 2 && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("midframe cell0 seen", {31'd0, q_a.size() >= 2}, 1);
    write_a("midframe write", 1'b0, 2'd0, 8'h42);
    wait_idle("midframe", 1'b0);
    exp_row(8'h80, 40'h20202020, 4);
    exp_row(8'hC0, 40'h20204120, 4);
    exp_row(8'h80, 40'h42202020, 4);
    exp_row(8'hC0, 40'h20204120, 4);
    cmp_bytes("midframe", 1'b0);

    refresh_a("refresh");
    wait_idle("refresh", 1'b0);
    exp_row(8'h80, 40'h42202020, 4);
    exp_row(8'hC0, 40'h20204120, 4);
    cmp_bytes("refresh", 1'b0);
    repeat (40) @(negedge clk);
    chk("refresh no extra", q_a.size(), 0);
    chk("refresh stays idle", {31'd0, busy}, 0);

    wait_idle("b powerup", 1'b1);
    q_b.delete();
    write_b(2'd0, 3'd5, 8'h55);
    write_b(2'd3, 3'd0, 8'h55);
    write_b(2'd3, 3'd7, 8'h55);
    hi = 0;
    repeat (30) begin
      @(negedge clk);
      if (busy_b) hi++;
    end
    chk("oor busy cycles", hi, 0);
    chk("oor no bytes", q_b.size(), 0);
    @(negedge clk);
    refresh_req_b = 1'b1;
    @(negedge clk);
    refresh_req_b = 1'b0;
    @(negedge clk);
    chk("oor refresh busy", {31'd0, busy_b}, 1);
    wait_idle("oor frame", 1'b1);
    exp_row(8'h80, 40'h2020202020, 5);
    exp_row(8'hC0, 40'h2020202020, 5);
    exp_row(8'h85, 40'h2020202020, 5);
    cmp_bytes("oor frame", 1'b1);

    refresh_a("rst pulse refresh");
    n = 0;
    while (!(lcd_en === 1'b1 && q_a.size() >= 3) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("rst pulse en high", {31'd0, lcd_en}, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst async en", {31'd0, lcd_en}, 0);
    chk("rst async data", {24'd0, lcd_data}, 0);
    chk("rst async busy", {31'd0, busy}, 1);
    repeat (2) @(negedge clk);
    q_a.delete();
    rise_a.delete();
    wid_a.delete();
    unstable_a.delete();
    @(negedge clk);
    rst_n = 1'b1;
    t0 = cyc;
    check_powerup("reinit", t0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
